// File: rtl/pll_lock_sequencer.sv
// PLL reset and lock sequencer.
// Drives the PLL reset, qualifies the synchronised lock flag with a filter and
// a timeout/retry loop, then releases the per-domain resets one by one.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// RESET_PLL | pll_rst held high for PLL_RST_CYCLES cycles (held while soft_reset)
// WAIT_LOCK | waiting for lk; retries through RESET_PLL after LOCK_TIMEOUT cycles
// FILTER    | lk must stay high until the timer reaches LOCK_FILTER
// RELEASE   | domain_rst bits fall in ascending order, STAGGER cycles apart
// RUN       | all domains out of reset, ready high; lk loss aborts
module pll_lock_sequencer #(
  parameter int NUM_CLOCKS     = 4,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_FILTER    = 1024,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STAGGER        = 8,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  locked,
  input  logic                  soft_reset,
  output logic                  pll_rst,
  output logic [NUM_CLOCKS-1:0] domain_rst,
  output logic                  ready,
  output logic [2:0]            state,
  output logic [CNT_WIDTH-1:0]  relock_count,
  output logic [CNT_WIDTH-1:0]  timeout_count
);

  localparam logic [2:0] RESET_PLL = 3'd0;
  localparam logic [2:0] WAIT_LOCK = 3'd1;
  localparam logic [2:0] FILTER    = 3'd2;
  localparam logic [2:0] RELEASE   = 3'd3;
  localparam logic [2:0] RUN       = 3'd4;

  // One shared timer; it must hold the largest terminal value of any state.
  localparam int REL_SPAN = (NUM_CLOCKS - 1) * STAGGER;
  localparam int M1       = (PLL_RST_CYCLES - 1 > LOCK_TIMEOUT - 1) ? PLL_RST_CYCLES - 1 : LOCK_TIMEOUT - 1;
  localparam int M2       = (LOCK_FILTER > REL_SPAN) ? LOCK_FILTER : REL_SPAN;
  localparam int T_MAX    = (M1 > M2) ? M1 : M2;
  localparam int TW       = (T_MAX < 2) ? 1 : $clog2(T_MAX + 1);

  localparam logic [TW-1:0] RST_LAST  = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] FILT_LAST = TW'(LOCK_FILTER);
  localparam logic [TW-1:0] REL_LAST  = TW'(REL_SPAN);

  logic          sync1;
  logic          lk;
  logic [TW-1:0] timer;

  // Two-flop synchroniser for the asynchronous PLL lock flag.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      lk    <= 1'b0;
    end else begin
      sync1 <= locked;
      lk    <= sync1;
    end
  end

  // Sequencer FSM with registered outputs and saturating event counters.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state         <= RESET_PLL;
      timer         <= '0;
      pll_rst       <= 1'b1;
      domain_rst    <= '1;
      ready         <= 1'b0;
      relock_count  <= '0;
      timeout_count <= '0;
    end else if (soft_reset) begin
      // Soft reset wins over lock loss and timeout and never counts.
      state      <= RESET_PLL;
      timer      <= '0;
      pll_rst    <= 1'b1;
      domain_rst <= '1;
      ready      <= 1'b0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (timer == RST_LAST) begin
            state   <= WAIT_LOCK;
            timer   <= '0;
            pll_rst <= 1'b0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        WAIT_LOCK: begin
          if (lk) begin
            state <= FILTER;
            timer <= '0;
          end else if (timer == TO_LAST) begin
            state   <= RESET_PLL;
            timer   <= '0;
            pll_rst <= 1'b1;
            if (timeout_count != '1) timeout_count <= timeout_count + CNT_WIDTH'(1);
          end else begin
            timer <= timer + TW'(1);
          end
        end
        FILTER: begin
          if (!lk) begin
            state <= WAIT_LOCK;
            timer <= '0;
          end else if (timer == FILT_LAST) begin
            state <= RELEASE;
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RELEASE, RUN: begin
          if (!lk) begin
            state      <= RESET_PLL;
            timer      <= '0;
            pll_rst    <= 1'b1;
            domain_rst <= '1;
            ready      <= 1'b0;
            if (relock_count != '1) relock_count <= relock_count + CNT_WIDTH'(1);
          end else if (state == RELEASE) begin
            // Bits only ever clear here, so they fall in ascending order.
            for (int i = 0; i < NUM_CLOCKS; i++) begin
              if (timer == TW'(i * STAGGER)) domain_rst[i] <= 1'b0;
            end
            if (timer == REL_LAST) begin
              state <= RUN;
              ready <= 1'b1;
            end else begin
              timer <= timer + TW'(1);
            end
          end
        end
        default: begin
          state      <= RESET_PLL;
          timer      <= '0;
          pll_rst    <= 1'b1;
          domain_rst <= '1;
          ready      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Testbench for pll_lock_sequencer: directed scenarios plus random lock
// activity, all compared each cycle against a phase/elapsed-time model.
module tb_pll_lock_sequencer;

  localparam int NC   = 4;
  localparam int PRC  = 16;
  localparam int LF   = 1024;
  localparam int LT   = 32;
  localparam int ST   = 8;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  localparam int RP = 0, WL = 1, FL = 2, RL = 3, RN = 4;

  logic          refclk = 1'b0;
  logic          rst = 1'b0;
  logic          locked = 1'b0;
  logic          soft_reset = 1'b0;
  logic          pll_rst;
  logic [NC-1:0] domain_rst;
  logic          ready;
  logic [2:0]    state;
  logic [CW-1:0] relock_count;
  logic [CW-1:0] timeout_count;

  pll_lock_sequencer #(
    .NUM_CLOCKS(NC), .PLL_RST_CYCLES(PRC), .LOCK_FILTER(LF),
    .LOCK_TIMEOUT(LT), .STAGGER(ST), .CNT_WIDTH(CW)
  ) dut (
    .refclk(refclk), .rst(rst), .locked(locked), .soft_reset(soft_reset),
    .pll_rst(pll_rst), .domain_rst(domain_rst), .ready(ready), .state(state),
    .relock_count(relock_count), .timeout_count(timeout_count)
  );

  always #5 refclk = ~refclk;

  int total = 0;
  int bad = 0;

  // Model: current phase, edges elapsed in it, lock pipeline, event counts.
  int   m_phase, m_n, m_rc, m_tc;
  logic m_s1, m_lk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = RP; m_n = 0; m_rc = 0; m_tc = 0; m_s1 = 1'b0; m_lk = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_step();
    logic lk_now;
    lk_now = m_lk;
    m_lk   = m_s1;
    m_s1   = locked;
    if (soft_reset) begin
      m_phase = RP; m_n = 0;
    end else begin
      case (m_phase)
        RP: begin
          m_n++;
          if (m_n == PRC) begin m_phase = WL; m_n = 0; end
        end
        WL: begin
          if (lk_now) begin
            m_phase = FL; m_n = 0;
          end else begin
            m_n++;
            if (m_n == LT) begin
              m_phase = RP; m_n = 0;
              if (m_tc < CMAX) m_tc++;
            end
          end
        end
        FL: begin
          // LOCK_FILTER+1 consecutive lk-high cycles spent in FILTER.
          if (!lk_now) begin
            m_phase = WL; m_n = 0;
          end else begin
            m_n++;
            if (m_n == LF + 1) begin m_phase = RL; m_n = 0; end
          end
        end
        default: begin
          if (!lk_now) begin
            m_phase = RP; m_n = 0;
            if (m_rc < CMAX) m_rc++;
          end else if (m_phase == RL) begin
            m_n++;
            if (m_n == (NC - 1) * ST + 1) begin m_phase = RN; m_n = 0; end
          end
        end
      endcase
    end
  endtask

  function automatic logic [63:0] model_vec();
    logic [NC-1:0] d;
    logic [2:0]    ph;
    ph = m_phase[2:0];
    for (int i = 0; i < NC; i++)
      d[i] = (m_phase == RN) ? 1'b0 : (m_phase == RL) ? !(m_n > i * ST) : 1'b1;
    return 64'({ph, m_phase == RP, d, m_phase == RN, m_rc[CW-1:0], m_tc[CW-1:0]});
  endfunction

  task automatic tick();
    @(posedge refclk);
    if (!rst) model_step();
    #1;
    check("model", 64'({state, pll_rst, domain_rst, ready, relock_count, timeout_count}), model_vec());
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, 64'(state), 64'(0));
    check({tag, "_pll_rst"}, 64'(pll_rst), 64'(1));
    check({tag, "_domain_rst"}, 64'(domain_rst), 64'({NC{1'b1}}));
    check({tag, "_ready"}, 64'(ready), 64'(0));
    check({tag, "_relock"}, 64'(relock_count), 64'(0));
    check({tag, "_timeout"}, 64'(timeout_count), 64'(0));
  endtask

  initial begin
    int n;
    int hi_len, lo_len;

    // Power-on reset
    #2 rst = 1'b1;
    model_reset();
    #1 check_reset_values("por");
    repeat (3) tick();
    rst = 1'b0;

    // Nominal sequence: lock rises 10 cycles after pll_rst falls
    n = 0;
    while (pll_rst === 1'b1 && n < 100) begin tick(); n++; end
    check("pll_rst_width", 64'(n), 64'(PRC));
    repeat (10) tick();
    locked = 1'b1;
    n = 0;
    while (domain_rst[0] === 1'b1 && n < 3000) begin tick(); n++; end
    check("dom0_latency", 64'(n), 64'(LF + 5));
    for (int b = 1; b < NC; b++) begin
      n = 0;
      while (domain_rst[b] === 1'b1 && n < 100) begin tick(); n++; end
      check("dom_gap", 64'(n), 64'(ST));
      if (b == NC - 2) check("ready_early", 64'(ready), 64'(0));
    end
    check("ready_with_last_dom", 64'(ready), 64'(1));
    check("nominal_relock", 64'(relock_count), 64'(0));
    check("nominal_timeout", 64'(timeout_count), 64'(0));

    // Lock loss in RUN, then the full sequence again
    repeat (5) tick();
    locked = 1'b0;
    n = 0;
    while (!(pll_rst === 1'b1 && domain_rst === {NC{1'b1}}) && n < 20) begin tick(); n++; end
    check("loss_latency", 64'(n), 64'(3));
    check("loss_relock", 64'(relock_count), 64'(1));
    check("loss_ready", 64'(ready), 64'(0));
    n = 0;
    while (pll_rst === 1'b1 && n < 100) begin tick(); n++; end
    check("pll_rst_width2", 64'(n), 64'(PRC));
    locked = 1'b1;
    n = 0;
    while (ready !== 1'b1 && n < 3000) begin tick(); n++; end
    check("ready_latency2", 64'(n), 64'(LF + 5 + (NC - 1) * ST));

    // Filter glitch near filter count 500
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    n = 0;
    while (state !== 3'd2 && n < 100) begin tick(); n++; end
    repeat (500) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    n = 0;
    while (state !== 3'd1 && n < 10) begin tick(); n++; end
    check("glitch_to_wait", 64'(state), 64'(1));
    tick();
    check("glitch_to_filter", 64'(state), 64'(2));
    n = 0;
    while (domain_rst[0] === 1'b1 && n < 3000) begin tick(); n++; end
    check("glitch_release", 64'(n), 64'(LF + 2));
    check("soft_no_relock", 64'(relock_count), 64'(1));

    // Async reset mid-RELEASE, away from any clock edge
    n = 0;
    while (domain_rst[1] === 1'b1 && n < 20) begin tick(); n++; end
    check("dom1_low_before_rst", 64'(domain_rst), 64'({{(NC-2){1'b1}}, 2'b00}));
    #2 rst = 1'b1;
    #1 check_reset_values("async");
    model_reset();
    repeat (2) tick();
    rst = 1'b0;

    // Minimum latency with lock already high
    n = 0;
    while (ready !== 1'b1 && n < 3000) begin tick(); n++; end
    check("ready_from_rst", 64'(n), 64'(PRC + 2 + LF + 1 + (NC - 1) * ST));

    // Soft reset together with lock loss, held 20 cycles
    locked = 1'b0;
    tick();
    tick();
    soft_reset = 1'b1;
    tick();
    check("soft_loss_state", 64'(state), 64'(0));
    check("soft_loss_relock", 64'(relock_count), 64'(0));
    check("soft_loss_domains", 64'(domain_rst), 64'({NC{1'b1}}));
    n = 1;
    while (pll_rst === 1'b1 && n < 100) begin
      if (n == 20) soft_reset = 1'b0;
      tick();
      n++;
    end
    soft_reset = 1'b0;
    check("soft_extend", 64'(n), 64'(20 + PRC));

    // Timeout retry loop with lock held low
    n = 0;
    while (pll_rst !== 1'b1 && n < 100) begin tick(); n++; end
    check("wait_timeout", 64'(n), 64'(LT));
    check("timeout_one", 64'(timeout_count), 64'(1));
    n = 0;
    while (pll_rst === 1'b1 && n < 100) begin tick(); n++; end
    while (pll_rst !== 1'b1 && n < 200) begin tick(); n++; end
    check("retry_period", 64'(n), 64'(PRC + LT));
    repeat (256 * (PRC + LT)) tick();
    check("timeout_sat", 64'(timeout_count), 64'(CMAX));
    repeat (3 * (PRC + LT)) tick();
    check("timeout_hold", 64'(timeout_count), 64'(CMAX));

    // Random lock activity with occasional soft resets
    for (int seg = 0; seg < 12; seg++) begin
      hi_len = $urandom_range(20, 1300);
      lo_len = $urandom_range(1, 50);
      locked = 1'b1;
      repeat (hi_len) tick();
      locked = 1'b0;
      repeat (lo_len) tick();
      if ($urandom_range(0, 3) == 0) begin
        soft_reset = 1'b1;
        repeat ($urandom_range(1, 25)) tick();
        soft_reset = 1'b0;
      end
    end
    locked = 1'b1;
    repeat (1200) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
